// File: rtl/audio_rx_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_rx_deserializer_pkg
//  Description : Shared word width, receive FSM encoding and channel codes
//                for the I2S receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_rx_deserializer_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } rx_state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/audio_rx_deserializer_peak_meter.sv
`default_nettype none
// ============================================================================
//  Module      : audio_peak_meter
//  Description : Tracks the largest sample magnitude over a window of
//                PEAK_FRAMES stereo pairs and publishes bits [14:7] of it.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_peak_meter #(
  parameter int DATA_W      = audio_rx_deserializer_pkg::DATA_W,
  parameter int PEAK_FRAMES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_left,
  input  logic [DATA_W-1:0] sample_right,
  output logic [7:0]        peak_level
);

  localparam int FRAME_W = $clog2(PEAK_FRAMES);
  localparam logic [FRAME_W-1:0] c_last_frame = FRAME_W'(PEAK_FRAMES - 1);

  logic [DATA_W-2:0]  r_peak_acc;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [DATA_W-2:0]  w_abs_left;
  logic [DATA_W-2:0]  w_abs_right;
  logic [DATA_W-2:0]  w_max;

  // Magnitude in DATA_W-1 bits; the most negative code saturates to all ones.
  function automatic logic [DATA_W-2:0] sat_abs(input logic [DATA_W-1:0] x);
    logic [DATA_W-2:0] mag;
    if (!x[DATA_W-1])
      mag = x[DATA_W-2:0];
    else if (x[DATA_W-2:0] == '0)
      mag = '1;
    else
      mag = (~x[DATA_W-2:0]) + {{(DATA_W-2){1'b0}}, 1'b1};
    return mag;
  endfunction

  // Running maximum including the pair currently being presented.
  always_comb begin
    w_abs_left  = sat_abs(sample_left);
    w_abs_right = sat_abs(sample_right);
    w_max       = r_peak_acc;
    if (w_abs_left > w_max)  w_max = w_abs_left;
    if (w_abs_right > w_max) w_max = w_abs_right;
  end

  // Window accumulation; the last pair of a window publishes and restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak_acc  <= '0;
      r_frame_cnt <= '0;
      peak_level  <= '0;
    end else if (sample_valid) begin
      if (r_frame_cnt == c_last_frame) begin
        peak_level  <= w_max[DATA_W-2 -: 8];
        r_peak_acc  <= '0;
        r_frame_cnt <= '0;
      end else begin
        r_peak_acc  <= w_max;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_rx_deserializer
//  Description : I2S receiver. Synchronises bck/ws/data into clk, aligns to
//                word select, assembles left/right words and presents them
//                as a pair with a one-cycle valid strobe plus a peak level.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_rx_deserializer #(
  parameter int DATA_W      = audio_rx_deserializer_pkg::DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int PEAK_FRAMES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              audio_bck,
  input  logic              audio_ws,
  input  logic              audio_data,
  output logic [DATA_W-1:0] audio_out_left,
  output logic [DATA_W-1:0] audio_out_right,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              locked,
  output logic [7:0]        peak_level
);

  import audio_rx_deserializer_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] r_bck_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_bck_prev;
  logic                   r_ws_d;
  rx_state_e              r_state;
  rx_state_e              w_state_next;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_chan;
  logic [DATA_W-2:0]      r_shift;
  logic [DATA_W-1:0]      r_left_hold;
  logic                   r_left_valid;

  logic              w_bck_s;
  logic              w_ws_s;
  logic              w_data_s;
  logic              w_bck_rise;
  logic              w_ws_edge;
  logic              w_start;
  logic              w_shift;
  logic              w_latch;
  logic              w_err;
  logic [DATA_W-1:0] w_word;

  assign w_bck_s    = r_bck_sync[SYNC_STAGES-1];
  assign w_ws_s     = r_ws_sync[SYNC_STAGES-1];
  assign w_data_s   = r_data_sync[SYNC_STAGES-1];
  assign w_bck_rise = w_bck_s & ~r_bck_prev;
  assign w_ws_edge  = w_bck_rise & (w_ws_s != r_ws_d);
  // The bit arriving on the latch rise completes the word.
  assign w_word     = {r_shift, w_data_s};

  // Input synchronisers, bck edge history and ws value at the last bck rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bck_sync  <= '0;
      r_ws_sync   <= '0;
      r_data_sync <= '0;
      r_bck_prev  <= 1'b0;
      r_ws_d      <= 1'b0;
    end else begin
      r_bck_sync  <= {r_bck_sync[SYNC_STAGES-2:0], audio_bck};
      r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], audio_ws};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], audio_data};
      r_bck_prev  <= w_bck_s;
      if (w_bck_rise) r_ws_d <= w_ws_s;
    end
  end

  // Framing state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and datapath controls; the ws-edge rise never carries data.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_latch      = 1'b0;
    w_err        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ws_edge) begin
          w_start      = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ws_edge) begin
          w_start = 1'b1;
          w_err   = 1'b1;
        end else if (w_bck_rise) begin
          w_shift = 1'b1;
          if (r_bit_cnt == c_last_bit) begin
            w_latch      = 1'b1;
            w_state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_ws_edge) begin
          w_start      = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Word assembly, left holding register and pair presentation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt       <= '0;
      r_chan          <= LEFT;
      r_shift         <= '0;
      r_left_hold     <= '0;
      r_left_valid    <= 1'b0;
      audio_out_left  <= '0;
      audio_out_right <= '0;
      sample_valid    <= 1'b0;
      frame_err       <= 1'b0;
      locked          <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= w_err;
      if (w_start) begin
        r_bit_cnt <= '0;
        r_chan    <= w_ws_s;
        locked    <= 1'b1;
        // A truncated word or the start of a new frame voids any held left.
        if (w_err || (w_ws_s == LEFT)) r_left_valid <= 1'b0;
      end
      if (w_shift) begin
        r_shift   <= w_word[DATA_W-2:0];
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_latch) begin
        if (r_chan == LEFT) begin
          r_left_hold  <= w_word;
          r_left_valid <= 1'b1;
        end else if (r_left_valid) begin
          audio_out_left  <= r_left_hold;
          audio_out_right <= w_word;
          sample_valid    <= 1'b1;
          r_left_valid    <= 1'b0;
        end
      end
    end
  end

  audio_peak_meter #(
    .DATA_W      (DATA_W),
    .PEAK_FRAMES (PEAK_FRAMES)
  ) u_peak_meter (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_left  (audio_out_left),
    .sample_right (audio_out_right),
    .peak_level   (peak_level)
  );

endmodule
`default_nettype wire

// File: tb/tb_audio_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_rx_deserializer
//  Description : Directed bench for the I2S receiver with a pair scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bck = 1'b0;
  logic        ws = 1'b0;
  logic        data = 1'b0;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic        sample_valid;
  logic        frame_err;
  logic        locked;
  logic [7:0]  peak_level;

  int checks = 0;
  int failures = 0;
  int sv_cnt = 0;
  int err_cnt = 0;
  int exp_sv = 0;
  logic [31:0] sb_q[$];

  audio_rx_deserializer #(
    .DATA_W      (16),
    .SYNC_STAGES (2),
    .PEAK_FRAMES (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .audio_bck       (bck),
    .audio_ws        (ws),
    .audio_data      (data),
    .audio_out_left  (out_left),
    .audio_out_right (out_right),
    .sample_valid    (sample_valid),
    .frame_err       (frame_err),
    .locked          (locked),
    .peak_level      (peak_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pair must match the oldest expected pair.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      sv_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        check("pair_left", {16'h0, out_left}, {16'h0, e[31:16]});
        check("pair_right", {16'h0, out_right}, {16'h0, e[15:0]});
      end
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  // One bck period = 8 clk; ws/data change while bck is low.
  task automatic send_bit(input logic w, input logic d);
    bck = 1'b0; ws = w; data = d;
    repeat (4) @(negedge clk);
    bck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Rise 0 of a slot is the ws-edge rise (ignored); rises 1..16 carry MSB..LSB.
  task automatic send_slot(input logic w, input logic [15:0] word, input int nbits);
    for (int i = 0; i < nbits; i++)
      send_bit(w, (i >= 1 && i <= 16) ? word[16 - i] : 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbits);
    sb_q.push_back({l, r});
    exp_sv++;
    send_slot(1'b0, l, nbits);
    send_slot(1'b1, r, nbits);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check("rst_left", {16'h0, out_left}, 32'h0);
    check("rst_right", {16'h0, out_right}, 32'h0);
    check("rst_valid", {31'h0, sample_valid}, 32'h0);
    check("rst_err", {31'h0, frame_err}, 32'h0);
    check("rst_locked", {31'h0, locked}, 32'h0);
    check("rst_peak", {24'h0, peak_level}, 32'h0);
    rst = 1'b0;

    // 1: bck running, ws never changes -> no lock, no output
    repeat (3) send_slot(1'b0, 16'hFFFF, 32);
    check("idle_locked", {31'h0, locked}, 32'h0);
    check("idle_sv", sv_cnt, exp_sv);
    check("idle_left", {16'h0, out_left}, 32'h0);

    // 2: acquire on a right slot (dropped), then one full 32-bck-slot frame
    send_slot(1'b1, 16'h5555, 32);
    check("lock_after_edge", {31'h0, locked}, 32'h1);
    check("lock_no_sv", sv_cnt, exp_sv);
    send_frame(16'h1234, 16'hABCD, 32);
    check("basic_sv", sv_cnt, exp_sv);
    repeat (20) @(negedge clk);
    check("basic_hold_left", {16'h0, out_left}, 32'h1234);
    check("basic_hold_right", {16'h0, out_right}, 32'hABCD);

    // 3: 24-bck slots, extremes of range
    send_frame(16'h7FFF, 16'h8000, 24);
    check("wide_sv", sv_cnt, exp_sv);
    check("wide_no_err", err_cnt, 0);

    // 4: left word cut after 10 bits -> one error, orphan right dropped
    send_slot(1'b0, 16'hFFFF, 11);
    send_slot(1'b1, 16'h5A5A, 24);
    check("trunc_err", err_cnt, 1);
    check("trunc_no_sv", sv_cnt, exp_sv);
    check("trunc_keep_left", {16'h0, out_left}, 32'h7FFF);
    check("trunc_locked", {31'h0, locked}, 32'h1);
    send_frame(16'h0001, 16'h0002, 24);
    check("recover_sv", sv_cnt, exp_sv);
    check("recover_err", err_cnt, 1);

    // 5: peak windows of 4 pairs from a fresh reset
    rst = 1'b1; bck = 1'b0; ws = 1'b0; data = 1'b0;
    repeat (3) @(negedge clk);
    check("rst2_peak", {24'h0, peak_level}, 32'h0);
    check("rst2_locked", {31'h0, locked}, 32'h0);
    rst = 1'b0;
    send_slot(1'b1, 16'h0000, 24);
    send_frame(16'h0100, 16'h0000, 24);
    send_frame(16'h8000, 16'h0010, 24);
    send_frame(16'h0200, 16'h0300, 24);
    check("peak_mid_window", {24'h0, peak_level}, 32'h0);
    send_frame(16'h0000, 16'h0000, 24);
    check("peak_window1", {24'h0, peak_level}, 32'hFF);
    repeat (3) send_frame(16'h0080, 16'h0080, 24);
    check("peak_hold", {24'h0, peak_level}, 32'hFF);
    send_frame(16'h0080, 16'h0080, 24);
    check("peak_window2", {24'h0, peak_level}, 32'h01);
    check("peak_sv", sv_cnt, exp_sv);

    // 6: reset after 7 bits of a right word
    send_slot(1'b0, 16'h1111, 24);
    send_slot(1'b1, 16'h2222, 8);
    #2 rst = 1'b1;
    #1;
    check("midrst_left", {16'h0, out_left}, 32'h0);
    check("midrst_right", {16'h0, out_right}, 32'h0);
    check("midrst_locked", {31'h0, locked}, 32'h0);
    check("midrst_peak", {24'h0, peak_level}, 32'h0);
    bck = 1'b0; ws = 1'b0; data = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_slot(1'b1, 16'h0000, 24);
    check("reacq_locked", {31'h0, locked}, 32'h1);
    send_frame(16'h5A5A, 16'hC3C3, 24);
    check("reacq_sv", sv_cnt, exp_sv);
    check("final_err", err_cnt, 1);
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
